// File: rtl/uart_avms_host.sv
// uart_avms_host
// Avalon-MM master in front of uart_core. TX bytes from a valid/ready stream
// are buffered in a small FIFO and written to TXDATA after a successful
// STATUS poll. A level IRQ from uart_core triggers a RXDATA read; the byte is
// then held on a valid/ready output stream until the consumer takes it.
// Every Avalon strobe lasts one cycle. Address, byteenable and writedata are
// registered together with the strobe.
`timescale 1ns/1ps

module uart_avms_host #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned POLL_GAP    = 3,
    parameter logic [3:0]  ADDR_TXDATA = 4'h0,
    parameter logic [3:0]  ADDR_STATUS = 4'h1,
    parameter logic [3:0]  ADDR_RXDATA = 4'h2
) (
    input  logic                          clk_i,
    input  logic                          arst_n_i,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic [7:0]                    rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    input  logic                          irq_i,
    output logic [3:0]                    avm_address_o,
    output logic                          avm_byteenable_o,
    output logic                          avm_read_o,
    output logic                          avm_write_o,
    output logic [7:0]                    avm_writedata_o,
    input  logic [7:0]                    avm_readdata_i,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = (POLL_GAP > 0) ? GW'(POLL_GAP - 1) : '0;
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GAP    = 3'd1,
        ST_RD  = 3'd2,
        ST_CAP = 3'd3,
        TX_WR  = 3'd4,
        RX_RD  = 3'd5,
        RX_CAP = 3'd6
    } state_t;

    // FIFO storage and pointers
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_tx_ready;

    // Control and registered Avalon / RX stream outputs
    state_t        r_state;
    logic [GW-1:0] r_gap_cnt;
    logic [7:0]    r_rx_data;
    logic          r_rx_valid;
    logic [3:0]    r_avm_address;
    logic          r_avm_be;
    logic          r_avm_read;
    logic          r_avm_write;
    logic [7:0]    r_avm_wdata;

    logic          w_push;
    logic          w_pop;
    logic          w_fifo_empty;
    logic          w_irq_take;
    logic [LW-1:0] w_level_nxt;
    logic [7:0]    w_head;

    assign w_push       = tx_valid_i & r_tx_ready;
    assign w_pop        = (r_state == TX_WR);
    assign w_fifo_empty = (r_level == '0);
    // The RX slot must be free before another byte is pulled from uart_core
    assign w_irq_take   = irq_i & ~r_rx_valid;
    assign w_head       = r_mem[r_rd_ptr];

    // Next FIFO occupancy; a push and a pop in the same cycle cancel out
    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // FIFO data array; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data_i;
        end
    end

    // FIFO pointers, level and registered ready (pointers wrap naturally)
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_tx_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level    <= w_level_nxt;
            r_tx_ready <= (w_level_nxt != LVL_FULL);
        end
    end

    // Bus sequencer: strobes are registered on entry to ST_RD / TX_WR / RX_RD
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state       <= IDLE;
            r_gap_cnt     <= '0;
            r_rx_data     <= 8'h00;
            r_rx_valid    <= 1'b0;
            r_avm_address <= ADDR_STATUS;
            r_avm_be      <= 1'b0;
            r_avm_read    <= 1'b0;
            r_avm_write   <= 1'b0;
            r_avm_wdata   <= 8'h00;
        end else begin
            r_avm_read  <= 1'b0;
            r_avm_write <= 1'b0;
            r_avm_be    <= 1'b0;

            if (r_rx_valid && rx_ready_i) begin
                r_rx_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_irq_take) begin
                        r_state       <= RX_RD;
                        r_avm_read    <= 1'b1;
                        r_avm_be      <= 1'b1;
                        r_avm_address <= ADDR_RXDATA;
                    end else if (!w_fifo_empty) begin
                        if (POLL_GAP == 0) begin
                            r_state       <= ST_RD;
                            r_avm_read    <= 1'b1;
                            r_avm_be      <= 1'b1;
                            r_avm_address <= ADDR_STATUS;
                        end else begin
                            r_state   <= GAP;
                            r_gap_cnt <= '0;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                GAP: begin
                    if (w_irq_take) begin
                        r_state       <= RX_RD;
                        r_gap_cnt     <= '0;
                        r_avm_read    <= 1'b1;
                        r_avm_be      <= 1'b1;
                        r_avm_address <= ADDR_RXDATA;
                    end else if (r_gap_cnt == GAP_LAST) begin
                        r_state       <= ST_RD;
                        r_gap_cnt     <= '0;
                        r_avm_read    <= 1'b1;
                        r_avm_be      <= 1'b1;
                        r_avm_address <= ADDR_STATUS;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                ST_RD: begin
                    r_state <= ST_CAP;
                end
                ST_CAP: begin
                    // Read data arrives one cycle after the strobe
                    if (avm_readdata_i[0]) begin
                        r_state       <= TX_WR;
                        r_avm_write   <= 1'b1;
                        r_avm_be      <= 1'b1;
                        r_avm_address <= ADDR_TXDATA;
                        r_avm_wdata   <= w_head;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                TX_WR: begin
                    r_state <= IDLE;
                end
                RX_RD: begin
                    r_state <= RX_CAP;
                end
                RX_CAP: begin
                    r_rx_data  <= avm_readdata_i;
                    r_rx_valid <= 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready_o       = r_tx_ready;
    assign tx_level_o       = r_level;
    assign rx_data_o        = r_rx_data;
    assign rx_valid_o       = r_rx_valid;
    assign avm_address_o    = r_avm_address;
    assign avm_byteenable_o = r_avm_be;
    assign avm_read_o       = r_avm_read;
    assign avm_write_o      = r_avm_write;
    assign avm_writedata_o  = r_avm_wdata;

endmodule

// File: tb/tb_uart_avms_host.sv
// Directed bench for uart_avms_host with a small uart_core register responder.
// Cycle numbers count rising edges; an event logged with cyc == P happens in
// the first cycle after the edge that left cyc at P.
`timescale 1ns/1ps

module tb_uart_avms_host;

    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned POLL_GAP   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       irq = 1'b0;
    logic [3:0] avm_addr;
    logic       avm_be;
    logic       avm_read;
    logic       avm_write;
    logic [7:0] avm_wdata;
    logic [7:0] avm_rdata = 8'h00;
    logic [4:0] tx_level;

    uart_avms_host #(.FIFO_DEPTH(FIFO_DEPTH), .POLL_GAP(POLL_GAP)) dut (
        .clk_i            (clk),
        .arst_n_i         (rst_n),
        .tx_data_i        (tx_data),
        .tx_valid_i       (tx_valid),
        .tx_ready_o       (tx_ready),
        .rx_data_o        (rx_data),
        .rx_valid_o       (rx_valid),
        .rx_ready_i       (rx_ready),
        .irq_i            (irq),
        .avm_address_o    (avm_addr),
        .avm_byteenable_o (avm_be),
        .avm_read_o       (avm_read),
        .avm_write_o      (avm_write),
        .avm_writedata_o  (avm_wdata),
        .avm_readdata_i   (avm_rdata),
        .tx_level_o       (tx_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] addr;
        logic [7:0] data;
    } ev_t;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         push_cyc = 0;
    int         both_cnt = 0;
    int         be_bad = 0;
    int         wr_addr_bad = 0;
    ev_t        rd_q[$];
    ev_t        wr_q[$];
    logic [7:0] st_q[$];
    logic [7:0] st_dflt = 8'h01;
    logic [7:0] rx_byte = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Rising-edge counter
    always @(posedge clk) cyc <= cyc + 1;

    // uart_core responder: read data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (avm_read && avm_addr == 4'h1) begin
            if (st_q.size() > 0) avm_rdata <= st_q.pop_front();
            else                 avm_rdata <= st_dflt;
        end else if (avm_read && avm_addr == 4'h2) begin
            avm_rdata <= rx_byte;
        end else begin
            avm_rdata <= 8'h00;
        end
    end

    // Bus monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (avm_read)  rd_q.push_back('{cyc, avm_addr, 8'h00});
            if (avm_write) wr_q.push_back('{cyc, avm_addr, avm_wdata});
            if (avm_read && avm_write) both_cnt <= both_cnt + 1;
            if ((avm_read || avm_write) && !avm_be) be_bad <= be_bad + 1;
            if (avm_write && avm_addr != 4'h0) wr_addr_bad <= wr_addr_bad + 1;
        end
    end

    function automatic logic [7:0] t3_byte(input int i);
        case (i)
            0:       return 8'h48;
            1:       return 8'h45;
            2:       return 8'h4C;
            3:       return 8'h89;
            default: return 8'h10 + 8'(i);
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push1(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        push_cyc = cyc;
    endtask

    task automatic clear_logs();
        @(posedge clk);
        #1;
        rd_q.delete();
        wr_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pushed;
        int n2;
        bit pend;
        bit found;

        // Reset state
        #2 rst_n = 1'b0;
        tick(3);
        check_eq("rst_addr", avm_addr, 4'h1);
        check_eq("rst_strobes", {avm_read, avm_write, avm_be}, 3'b000);
        check_eq("rst_wdata", avm_wdata, 8'h00);
        check_eq("rst_rx", {rx_valid, rx_data}, 9'h000);
        check_eq("rst_level", tx_level, 5'd0);
        rst_n = 1'b1;
        tick(1);
        check_eq("rst_txready", tx_ready, 1'b1);

        // Single byte, status ready on first poll
        clear_logs();
        st_dflt = 8'h01;
        push1(8'h48);
        tick(15);
        check_eq("t1_nrd", rd_q.size(), 1);
        check_eq("t1_rd_addr", rd_q[0].addr, 4'h1);
        check_eq("t1_rd_lat", rd_q[0].cyc - push_cyc, POLL_GAP + 1);
        check_eq("t1_nwr", wr_q.size(), 1);
        check_eq("t1_wr_lat", wr_q[0].cyc - push_cyc, POLL_GAP + 3);
        check_eq("t1_wr_data", wr_q[0].data, 8'h48);
        check_eq("t1_level", tx_level, 5'd0);

        // Three busy polls then ready: reads every 6 cycles, one write
        clear_logs();
        st_q.push_back(8'h00);
        st_q.push_back(8'h00);
        st_q.push_back(8'h00);
        st_dflt = 8'h01;
        push1(8'h55);
        tick(35);
        check_eq("t2_nrd", rd_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t2_rd%0d_cyc", i), rd_q[i].cyc - push_cyc, 4 + 6 * i);
        end
        check_eq("t2_nwr", wr_q.size(), 1);
        check_eq("t2_wr_cyc", wr_q[0].cyc - push_cyc, 24);
        check_eq("t2_wr_data", wr_q[0].data, 8'h55);

        // Fill to full with status busy, 17th ignored, then drain in order
        clear_logs();
        st_dflt = 8'h00;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = t3_byte(i);
        end
        @(negedge clk);
        check_eq("t3_full_ready", tx_ready, 1'b0);
        check_eq("t3_full_level", tx_level, 5'd16);
        tx_data = 8'hEE;
        @(negedge clk);
        tx_valid = 1'b0;
        check_eq("t3_17th_level", tx_level, 5'd16);
        check_eq("t3_no_wr_busy", wr_q.size(), 0);
        st_dflt = 8'h01;
        tick(200);
        check_eq("t3_nwr", wr_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("t3_wr%0d", i), wr_q[i].data, t3_byte(i));
        end
        check_eq("t3_level", tx_level, 5'd0);

        // IRQ takes priority; second IRQ held off while RX slot is full
        clear_logs();
        st_dflt = 8'h01;
        rx_byte = 8'h0A;
        @(negedge clk);
        irq      = 1'b1;
        tx_data  = 8'h33;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        push_cyc = cyc;
        tick(30);
        check_eq("t4_first_addr", rd_q[0].addr, 4'h2);
        check_eq("t4_first_cyc", rd_q[0].cyc - push_cyc, 0);
        check_eq("t4_second_addr", rd_q[1].addr, 4'h1);
        n2 = 0;
        foreach (rd_q[i]) if (rd_q[i].addr == 4'h2) n2++;
        check_eq("t4_nrx_rd", n2, 1);
        check_eq("t4_rx_valid", rx_valid, 1'b1);
        check_eq("t4_rx_data", rx_data, 8'h0A);
        check_eq("t4_tx_wr", wr_q[0].data, 8'h33);
        rx_byte  = 8'h0B;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check_eq("t4_consumed", rx_valid, 1'b0);
        @(negedge clk);
        irq = 1'b0;
        tick(4);
        check_eq("t4_rx2_valid", rx_valid, 1'b1);
        check_eq("t4_rx2_data", rx_data, 8'h0B);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check_eq("t4_rx2_consumed", rx_valid, 1'b0);

        // Level 5 held by push-on-pop; 40 bytes cross the pointer wrap
        clear_logs();
        st_dflt = 8'h00;
        for (int i = 0; i < 5; i++) push1(8'hA0 + 8'(i));
        check_eq("t5_level5", tx_level, 5'd5);
        st_dflt = 8'h01;
        pushed = 5;
        pend = 1'b0;
        for (int c = 0; c < 800 && pushed < 40; c++) begin
            @(negedge clk);
            if (pend) check_eq("t5_lvl_hold", tx_level, 5'd5);
            if (avm_write) begin
                tx_valid = 1'b1;
                tx_data  = 8'hA0 + 8'(pushed);
                pushed++;
                pend = 1'b1;
            end else begin
                tx_valid = 1'b0;
                pend = 1'b0;
            end
        end
        @(negedge clk);
        tx_valid = 1'b0;
        if (pend) check_eq("t5_lvl_hold", tx_level, 5'd5);
        check_eq("t5_pushed", pushed, 40);
        tick(80);
        check_eq("t5_nwr", wr_q.size(), 40);
        for (int i = 0; i < 40; i++) begin
            check_eq($sformatf("t5_wr%0d", i), wr_q[i].data, 8'hA0 + 8'(i));
        end

        // Reset during TX_WR aborts everything
        clear_logs();
        rx_byte = 8'h5A;
        irq = 1'b1;
        tick(6);
        irq = 1'b0;
        check_eq("t6_rx_pre", rx_valid, 1'b1);
        st_dflt = 8'h01;
        push1(8'h77);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (avm_write) found = 1'b1;
        end
        check_eq("t6_saw_wr", found, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_async_strobes", {avm_read, avm_write}, 2'b00);
        check_eq("t6_async_rx", rx_valid, 1'b0);
        tick(2);
        rst_n = 1'b1;
        clear_logs();
        tick(30);
        check_eq("t6_nwr", wr_q.size(), 0);
        check_eq("t6_nrd", rd_q.size(), 0);
        check_eq("t6_level", tx_level, 5'd0);
        check_eq("t6_rx_valid", rx_valid, 1'b0);
        check_eq("t6_txready", tx_ready, 1'b1);

        check_eq("rd_wr_excl", both_cnt, 0);
        check_eq("be_on_xfer", be_bad, 0);
        check_eq("wr_addr", wr_addr_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
